// File: rtl/acc_stack.sv
// Ahmes accumulator with carry-based shift/rotate, N/Z flags and a LIFO save stack.
// Commands are taken on a valid/ready handshake; results appear on ac_out the cycle after acceptance.
module acc_stack #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] ac_out,
  output logic             carry_out,
  output logic             n_flag,
  output logic             z_flag,
  output logic [CW-1:0]    depth_count,
  output logic             stack_full,
  output logic             stack_empty,
  output logic             stack_err
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_LOAD = 3'b001,
    OP_CLR  = 3'b010,
    OP_SHL  = 3'b011,
    OP_SHR  = 3'b100,
    OP_ROL  = 3'b101,
    OP_PUSH = 3'b110,
    OP_POP  = 3'b111
  } op_e;

  logic [WIDTH-1:0] ac_q, ac_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    depth_q, depth_d;
  logic             err_q, err_d;
  logic             ready_q;
  logic             pushEn;
  logic [AW-1:0]    pushIdx, popIdx;
  logic [WIDTH-1:0] stack_q [DEPTH];

  assign pushIdx = AW'(depth_q);
  assign popIdx  = AW'(depth_q - CW'(1));

  always_comb begin
    ac_d    = ac_q;
    carry_d = carry_q;
    depth_d = depth_q;
    err_d   = err_q;
    pushEn  = 1'b0;
    if (op_valid && ready_q) begin
      case (op_e'(op))
        OP_NOP: ;
        OP_LOAD: ac_d = data_in;
        OP_CLR: begin
          ac_d    = '0;
          carry_d = 1'b0;
        end
        OP_SHL: begin
          carry_d = ac_q[WIDTH-1];
          ac_d    = {ac_q[WIDTH-2:0], 1'b0};
        end
        OP_SHR: begin
          carry_d = ac_q[0];
          ac_d    = {1'b0, ac_q[WIDTH-1:1]};
        end
        OP_ROL: begin
          carry_d = ac_q[WIDTH-1];
          ac_d    = {ac_q[WIDTH-2:0], carry_q};
        end
        OP_PUSH: begin
          if (stack_full) begin
            err_d = 1'b1;
          end else begin
            pushEn  = 1'b1;
            depth_d = depth_q + CW'(1);
          end
        end
        OP_POP: begin
          if (stack_empty) begin
            err_d = 1'b1;
          end else begin
            ac_d    = stack_q[popIdx];
            depth_d = depth_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Stack entries are not reset; depth_q alone defines which ones are valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      ac_q    <= '0;
      carry_q <= 1'b0;
      depth_q <= '0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      ac_q    <= ac_d;
      carry_q <= carry_d;
      depth_q <= depth_d;
      err_q   <= err_d;
      ready_q <= 1'b1;
      if (pushEn) begin
        stack_q[pushIdx] <= ac_q;
      end
    end
  end

  assign op_ready    = ready_q;
  assign ac_out      = ac_q;
  assign carry_out   = carry_q;
  assign n_flag      = ac_q[WIDTH-1];
  assign z_flag      = (ac_q == '0);
  assign depth_count = depth_q;
  assign stack_full  = (depth_q == CW'(DEPTH));
  assign stack_empty = (depth_q == '0);
  assign stack_err   = err_q;

endmodule
